// File: rtl/ara_inval_sequencer.sv
// Turns AXI write-burst descriptors into one L1 D-cache line invalidation per line.
// Define INVAL_SEQ_MERGE_EN to skip a loaded first line equal to the line just issued.
module ara_inval_sequencer #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned MaxTxns     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         desc_valid_i,
    output logic                         desc_ready_o,
    input  logic [AddrWidth-1:0]         desc_addr_i,
    input  logic [7:0]                   desc_len_i,
    input  logic [2:0]                   desc_size_i,
    output logic [AddrWidth-1:0]         inval_addr_o,
    output logic                         inval_valid_o,
    input  logic                         inval_ready_i,
    output logic [$clog2(MaxTxns):0]     pending_o,
    output logic                         busy_o
);

    localparam int unsigned PtrW = $clog2(MaxTxns);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(L1LineWidth - 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] fifo_addr [MaxTxns];
    logic [7:0]           fifo_len  [MaxTxns];
    logic [2:0]           fifo_size [MaxTxns];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            fifo_full, fifo_empty;
    logic            push, pop;

    logic [AddrWidth-1:0] cur_q, cur_d;
    logic [AddrWidth-1:0] last_q, last_d;

    logic [AddrWidth-1:0] head_addr;
    logic [7:0]           head_len;
    logic [2:0]           head_size;
    logic [8:0]           beats;
    logic [AddrWidth:0]   span;
    logic [AddrWidth:0]   end_ext;
    logic [AddrWidth-1:0] end_addr;
    logic [AddrWidth-1:0] head_first, head_last;
    logic [AddrWidth-1:0] load_cur;
    logic                 single, hit, hs, at_last;

    assign fifo_full  = (count_q == CntW'(MaxTxns));
    assign fifo_empty = (count_q == '0);

    assign desc_ready_o = !fifo_full || !en_i;
    assign push         = desc_valid_i && desc_ready_o && en_i;

    assign head_addr = fifo_addr[rd_ptr_q];
    assign head_len  = fifo_len[rd_ptr_q];
    assign head_size = fifo_size[rd_ptr_q];

    // Line math runs one bit wider so a burst past the top of memory clamps.
    assign beats    = {1'b0, head_len} + 9'd1;
    assign span     = {{(AddrWidth - 8){1'b0}}, beats} << head_size;
    assign end_ext  = {1'b0, head_addr} + span - {{AddrWidth{1'b0}}, 1'b1};
    assign end_addr = end_ext[AddrWidth] ? '1 : end_ext[AddrWidth-1:0];

    assign head_first = head_addr & LineMask;
    assign head_last  = end_addr & LineMask;
    assign single     = (head_first == head_last);

    assign hs      = (state_q == ISSUE) && inval_ready_i;
    assign at_last = (cur_q == last_q);

`ifdef INVAL_SEQ_MERGE_EN
    logic [AddrWidth-1:0] merge_addr_q;
    logic                 merge_vld_q;

    // While chaining, the line handshaking this cycle is the last issued one.
    always_comb begin
        hit = 1'b0;
        if (state_q == ISSUE) begin
            hit = (head_first == cur_q);
        end else begin
            hit = merge_vld_q && (head_first == merge_addr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            merge_addr_q <= '0;
            merge_vld_q  <= 1'b0;
        end else begin
            if (hs) begin
                merge_addr_q <= cur_q;
                merge_vld_q  <= 1'b1;
            end
            if (state_d == IDLE) begin
                merge_vld_q <= 1'b0;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign load_cur = hit ? (head_first + LineStep) : head_first;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!(hit && single)) begin
                        state_d = ISSUE;
                        cur_d   = load_cur;
                        last_d  = head_last;
                    end
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (!at_last) begin
                        cur_d = cur_q + LineStep;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                        if (hit && single) begin
                            state_d = IDLE;
                        end else begin
                            cur_d  = load_cur;
                            last_d = head_last;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= desc_addr_i;
            fifo_len[wr_ptr_q]  <= desc_len_i;
            fifo_size[wr_ptr_q] <= desc_size_i;
        end
    end

    assign inval_valid_o = (state_q == ISSUE);
    assign inval_addr_o  = cur_q;
    assign pending_o     = count_q;
    assign busy_o        = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ara_inval_sequencer.sv
// Directed bench for ara_inval_sequencer; honours INVAL_SEQ_MERGE_EN.
// Inputs change and outputs are checked on the falling clock edge.
module tb_ara_inval_sequencer;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [63:0] desc_addr_i;
    logic [7:0]  desc_len_i;
    logic [2:0]  desc_size_i;
    logic [63:0] inval_addr_o;
    logic        inval_valid_o;
    logic        inval_ready_i;
    logic [2:0]  pending_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ara_inval_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .desc_valid_i  (desc_valid_i),
        .desc_ready_o  (desc_ready_o),
        .desc_addr_i   (desc_addr_i),
        .desc_len_i    (desc_len_i),
        .desc_size_i   (desc_size_i),
        .inval_addr_o  (inval_addr_o),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .pending_o     (pending_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] a, input logic [7:0] l,
                        input logic [2:0] s);
        desc_valid_i = 1'b1;
        desc_addr_i  = a;
        desc_len_i   = l;
        desc_size_i  = s;
    endtask

    // Push one descriptor into an idle block, ready held high, and
    // expect n consecutive lines starting at first.
    task automatic burst(input string tag, input logic [63:0] a,
                         input logic [7:0] l, input logic [2:0] s,
                         input logic [63:0] first, input int n);
        inval_ready_i = 1'b1;
        push(a, l, s);
        nclk();
        desc_valid_i = 1'b0;
        nclk();
        for (int k = 0; k < n; k++) begin
            chk({tag, "_v"}, inval_valid_o, 1);
            chk({tag, "_a"}, inval_addr_o, first + 64'(16 * k));
            nclk();
        end
        chk({tag, "_end"}, inval_valid_o, 0);
    endtask

    logic        seen;
    logic [63:0] exp_seq [6];

    initial begin
        rst_ni        = 1'b0;
        en_i          = 1'b1;
        desc_valid_i  = 1'b0;
        desc_addr_i   = '0;
        desc_len_i    = '0;
        desc_size_i   = '0;
        inval_ready_i = 1'b0;
        nclk();
        nclk();
        rst_ni = 1'b1;
        nclk();
        chk("rst_valid", inval_valid_o, 0);
        chk("rst_addr", inval_addr_o, 0);
        chk("rst_ready", desc_ready_o, 1);
        chk("rst_pend", pending_o, 0);
        chk("rst_busy", busy_o, 0);

        // single line, latency t+2
        inval_ready_i = 1'b1;
        push(64'h1000, 8'd0, 3'd3);
        nclk();
        desc_valid_i = 1'b0;
        chk("t1_v1", inval_valid_o, 0);
        chk("t1_pend1", pending_o, 1);
        chk("t1_busy1", busy_o, 1);
        nclk();
        chk("t1_v2", inval_valid_o, 1);
        chk("t1_a2", inval_addr_o, 64'h1000);
        nclk();
        chk("t1_v3", inval_valid_o, 0);
        chk("t1_busy3", busy_o, 0);

        burst("t2", 64'h100C, 8'd1, 3'd3, 64'h1000, 2);
        burst("sz0", 64'h700E, 8'd3, 3'd0, 64'h7000, 2);
        burst("sz5", 64'h8000, 8'd1, 3'd5, 64'h8000, 4);
        burst("clamp", 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3,
              64'hFFFF_FFFF_FFFF_FFF0, 1);

        // stall, fill the FIFO, then drain without bubbles
        nclk();
        inval_ready_i = 1'b0;
        push(64'h2000, 8'd3, 3'd3);
        nclk();
        desc_valid_i = 1'b0;
        repeat (5) nclk();
        chk("t3_hold_v", inval_valid_o, 1);
        chk("t3_hold_a", inval_addr_o, 64'h2000);
        for (int i = 0; i < 4; i++) begin
            push(64'h5000 + 64'(16 * i), 8'd0, 3'd3);
            nclk();
        end
        desc_valid_i = 1'b0;
        chk("t3_pend4", pending_o, 4);
        chk("t3_full", desc_ready_o, 0);
        chk("t3_still", inval_addr_o, 64'h2000);
        inval_ready_i = 1'b1;
        exp_seq[0] = 64'h2000;
        exp_seq[1] = 64'h2010;
        exp_seq[2] = 64'h5000;
        exp_seq[3] = 64'h5010;
        exp_seq[4] = 64'h5020;
        exp_seq[5] = 64'h5030;
        for (int i = 0; i < 6; i++) begin
            chk("t3_seq_v", inval_valid_o, 1);
            chk("t3_seq_a", inval_addr_o, exp_seq[i]);
            if (i == 2) chk("t3_pend3", pending_o, 3);
            nclk();
        end
        chk("t3_done", inval_valid_o, 0);
        chk("t3_idle", busy_o, 0);

        // coherence disabled: dropped
        en_i = 1'b0;
        push(64'h3000, 8'd7, 3'd3);
        chk("t4_ready", desc_ready_o, 1);
        nclk();
        desc_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | inval_valid_o | (pending_o != 0);
            nclk();
        end
        chk("t4_quiet", seen, 0);
        chk("t4_pend", pending_o, 0);
        en_i = 1'b1;

        // async reset mid-issue
        inval_ready_i = 1'b0;
        push(64'h2000, 8'd3, 3'd3);
        nclk();
        push(64'h6000, 8'd0, 3'd3);
        nclk();
        push(64'h6010, 8'd0, 3'd3);
        nclk();
        desc_valid_i = 1'b0;
        chk("t5_a0", inval_addr_o, 64'h2000);
        inval_ready_i = 1'b1;
        nclk();
        inval_ready_i = 1'b0;
        chk("t5_a1", inval_addr_o, 64'h2010);
        chk("t5_pend", pending_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("t5_rst_v", inval_valid_o, 0);
        chk("t5_rst_p", pending_o, 0);
        chk("t5_rst_b", busy_o, 0);
        nclk();
        rst_ni = 1'b1;
        inval_ready_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nclk();
            seen = seen | inval_valid_o;
        end
        chk("t5_stale", seen, 0);
        chk("t5_busy", busy_o, 0);

        // duplicate first line back to back
        push(64'h4000, 8'd0, 3'd3);
        nclk();
        push(64'h4008, 8'd0, 3'd3);
        nclk();
        desc_valid_i = 1'b0;
        chk("t6_v0", inval_valid_o, 1);
        chk("t6_a0", inval_addr_o, 64'h4000);
        nclk();
`ifdef INVAL_SEQ_MERGE_EN
        chk("t6_merged", inval_valid_o, 0);
`else
        chk("t6_v1", inval_valid_o, 1);
        chk("t6_a1", inval_addr_o, 64'h4000);
        nclk();
        chk("t6_end", inval_valid_o, 0);
`endif
        nclk();
        chk("t6_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
